subleq_mem_sequencer: RTL and testbench
=======================================

Name: subleq_mem_sequencer

Overview:
- Memory-side sequencer for the SUBLEQ core. It drives the memory address, write strobe and write data, and consumes the read data returned one cycle after each address.
- Executes one SUBLEQ step per pass: fetch A, B, C at PC..PC+2, read mem[A] and mem[B], write mem[B]-mem[A] back to mem[B], then branch to C if the result is <= 0 (signed).
- Sits between the core control and a synchronous single-port memory; it is the address/write producer for the read-data path.

Parameters:
- WORD_SIZE, 16 (tied to `WORD_SIZE from defines.vh), width of words, addresses and PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock.
- areset  input  1  reset, synchronous, active-high.
- run  input  1  enable; sampled in IDLE and at the end of each step.
- data_in  input  WORD_SIZE  memory read data, valid one cycle after the address it answers (we=0).
- addr  output  WORD_SIZE  memory address.
- we  output  1  memory write strobe; the write commits at the clk edge ending the cycle.
- data_out  output  WORD_SIZE  memory write data, meaningful only when we=1.
- pc  output  WORD_SIZE  current program counter.
- step_done  output  1  one-cycle pulse after each completed write.
- halted  output  1  high once halt is reached; cleared only by reset.

Behaviour:
- The memory contract is synchronous read: addr presented in cycle n gives data_in in cycle n+1.
- States are IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, LOAD_B, WRITE, HALT.
- Internal registers are ra, rb, rc, va, vb (all WORD_SIZE) and state.
- Reset (areset high at a clk edge):
  - state=IDLE, pc=RESET_PC, ra/rb/rc/va/vb=0.
  - step_done=0, halted=0.
  - Resulting outputs: addr=RESET_PC, we=0, data_out=0.
  - Reset overrides run and any in-progress step; a pending write is never issued.
- Per-state outputs and register captures at the end of the cycle:
  - IDLE: addr=pc, we=0. Go to FETCH_A if run=1, else stay.
  - FETCH_A: addr=pc.
  - FETCH_B: addr=pc+1; ra<=data_in.
  - FETCH_C: addr=pc+2; rb<=data_in.
  - READ_A: addr=ra; rc<=data_in.
  - READ_B: addr=rb; va<=data_in.
  - LOAD_B: addr=rb, we=0; vb<=data_in.
  - WRITE: addr=rb, we=1, data_out=vb-va (modulo 2^WORD_SIZE).
    - Let r be the result. pc<= (r[MSB]=1 or r=0) ? rc : pc+3.
    - step_done<=1 for exactly the next cycle.
  - HALT: addr=pc, we=0, halted=1 held; no further memory activity until reset.
- Transitions from WRITE:
  - Go to HALT if the next pc equals all-ones.
  - Otherwise go to FETCH_A if run=1, or IDLE if run=0.
- we is high only in WRITE. data_out is 0 in every state except WRITE.
- The output decode is combinational from registers only; data_in never reaches addr, we or data_out combinationally.
- Latency: 7 cycles per step, FETCH_A through WRITE. New pc and step_done are visible in the cycle after WRITE.
- Address arithmetic pc+1, pc+2, pc+3 wraps modulo 2^WORD_SIZE. For example, pc=0xFFFE fetches 0xFFFE, 0xFFFF, 0x0000.
- Deasserting run mid-step has no effect until WRITE completes; the step always finishes.
- Self-modifying code is legal: a write to pc..pc+2 takes effect on the next fetch.
- If rb equals ra, va and vb read the same word and the result is 0, so the branch is taken.

Test Plan:
1. Reset: hold areset 2 cycles with run=1 -> pc=0, addr=0, we=0, data_out=0, step_done=0, halted=0.
2. No-branch step: mem[0..2]={10,11,20}, mem[10]=3, mem[11]=8, run=1.
   - Address sequence 0,1,2,10,11,11(we=0),11(we=1, data_out=5).
   - Then mem[11]=5, pc=3, step_done high exactly 1 cycle, next addr=3.
3. Zero branch: same program with mem[10]=8, mem[11]=8 -> write data 0, pc=20.
4. Negative branch: mem[10]=8, mem[11]=3 -> data_out=0xFFFB, pc=20.
5. Halt and wrap:
   - pc=0xFFFE start: fetch addresses 0xFFFE, 0xFFFF, 0x0000.
   - Program with C=0xFFFF and result<=0: halted=1 after WRITE, we stays 0, pc=0xFFFF held for 20 cycles.
6. Run and reset mid-step:
   - Drop run during READ_A -> step completes (we pulse seen), then IDLE with addr=pc.
   - Assert areset during LOAD_B -> no we pulse, state IDLE, pc=0.

Source files
------------

// File: rtl/subleq_mem_sequencer.sv
// subleq_mem_sequencer
//
// Memory-side sequencer for the SUBLEQ core. Each pass runs one SUBLEQ step
// against a synchronous single-port memory:
//   fetch A, B, C from pc..pc+2, read mem[A] and mem[B],
//   write mem[B]-mem[A] back to mem[B], then branch to C when the result
//   is <= 0 (signed), otherwise continue at pc+3.
// The memory answers an address presented in cycle n with data_in in
// cycle n+1, so every register capture below takes the word requested by
// the previous state. Address arithmetic wraps modulo 2^WORD_SIZE.
// Reaching pc == all-ones ends execution; only areset leaves HALT.
//
// Ports:
//   clk        clock
//   areset     synchronous, active-high reset
//   run        start/continue enable, sampled in IDLE and in WRITE
//   data_in    memory read data (one cycle after addr)
//   addr       memory address
//   we         memory write strobe (high only in WRITE)
//   data_out   memory write data (zero whenever we is low)
//   pc         current program counter
//   step_done  one-cycle pulse in the cycle after each write
//   halted     high while in HALT
//
// addr, we and data_out decode from registered state only; data_in never
// reaches them combinationally.

module subleq_mem_sequencer #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] addr,
  output logic                 we,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 step_done,
  output logic                 halted
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH_A = 4'd1,
    FETCH_B = 4'd2,
    FETCH_C = 4'd3,
    READ_A  = 4'd4,
    READ_B  = 4'd5,
    LOAD_B  = 4'd6,
    WRITE   = 4'd7,
    HALT    = 4'd8
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_SIZE-1:0] ra;
  logic [WORD_SIZE-1:0] rb;
  logic [WORD_SIZE-1:0] rc;
  logic [WORD_SIZE-1:0] va;
  logic [WORD_SIZE-1:0] vb;
  logic [WORD_SIZE-1:0] result;
  logic [WORD_SIZE-1:0] pc_step;
  logic                 branch;

  // Result of the current step and the pc it selects. Only meaningful in
  // WRITE, when va and vb both hold the words read for this step.
  assign result  = vb - va;
  assign branch  = result[WORD_SIZE-1] | (result == '0);
  assign pc_step = branch ? rc : pc + WORD_SIZE'(3);

  // State and datapath registers. Each capture stores the word answered for
  // the address issued by the previous state.
  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      va        <= '0;
      vb        <= '0;
      step_done <= 1'b0;
    end else begin
      state     <= state_next;
      step_done <= (state == WRITE);
      case (state)
        FETCH_B: ra <= data_in;  // mem[pc]
        FETCH_C: rb <= data_in;  // mem[pc+1]
        READ_A:  rc <= data_in;  // mem[pc+2]
        READ_B:  va <= data_in;  // mem[ra]
        LOAD_B:  vb <= data_in;  // mem[rb]
        WRITE:   pc <= pc_step;
        default: ;
      endcase
    end
  end

  // Next state and memory-side outputs.
  always_comb begin
    state_next = state;
    addr       = pc;
    we         = 1'b0;
    data_out   = '0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH_A;
      end
      FETCH_A: begin
        state_next = FETCH_B;
      end
      FETCH_B: begin
        addr       = pc + WORD_SIZE'(1);
        state_next = FETCH_C;
      end
      FETCH_C: begin
        addr       = pc + WORD_SIZE'(2);
        state_next = READ_A;
      end
      READ_A: begin
        addr       = ra;
        state_next = READ_B;
      end
      READ_B: begin
        addr       = rb;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        // Holds rb for a second cycle while mem[rb] returns.
        addr       = rb;
        state_next = LOAD_B == LOAD_B ? WRITE : WRITE;
      end
      WRITE: begin
        addr     = rb;
        we       = 1'b1;
        data_out = result;
        // An all-ones pc is the halt address, whether reached by branch
        // or by pc+3.
        if (pc_step == '1)  state_next = HALT;
        else if (run)       state_next = FETCH_A;
        else                state_next = IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_subleq_mem_sequencer.sv
// tb_subleq_mem_sequencer
//
// Bench for subleq_mem_sequencer. A synchronous-read memory model answers the
// DUT; programs are loaded through a side port while the DUT is held in
// reset. Directed vectors come from a table; multi-cycle corner cases
// (wrap, halt, run drop, reset mid-step) are hand-written; random programs
// are checked against a SUBLEQ interpreter kept in ref_mem/ref_pc.

module tb_subleq_mem_sequencer;

  localparam int W = 16;

  logic         clk;
  logic         areset;
  logic         run;
  logic [W-1:0] data_in;
  logic [W-1:0] addr;
  logic         we;
  logic [W-1:0] data_out;
  logic [W-1:0] pc;
  logic         step_done;
  logic         halted;

  int checks;
  int errors;

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  subleq_mem_sequencer #(
    .WORD_SIZE (W),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .run       (run),
    .data_in   (data_in),
    .addr      (addr),
    .we        (we),
    .data_out  (data_out),
    .pc        (pc),
    .step_done (step_done),
    .halted    (halted)
  );

  // --------------------------------------------------------- memory model
  logic [W-1:0] mem [0:65535];
  logic         load_en;
  logic         clear_req;
  logic [W-1:0] load_addr;
  logic [W-1:0] load_data;

  initial begin
    data_in = '0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (clear_req) begin
        for (int i = 0; i < 65536; i++) mem[i] <= '0;
      end else if (load_en) begin
        mem[load_addr] <= load_data;
      end else if (we) begin
        mem[addr] <= data_out;
      end
      data_in <= mem[addr];
    end
  end

  // -------------------------------------------------------- reference model
  logic [W-1:0] ref_mem [0:65535];
  logic [W-1:0] ref_pc;

  task automatic model_step(output logic [W-1:0] p0, output logic [W-1:0] a,
                            output logic [W-1:0] b, output logic [W-1:0] r,
                            output logic [W-1:0] npc);
    logic [W-1:0] c;
    logic [W-1:0] p1;
    logic [W-1:0] p2;
    p0 = ref_pc;
    p1 = p0 + W'(1);
    p2 = p0 + W'(2);
    a  = ref_mem[p0];
    b  = ref_mem[p1];
    c  = ref_mem[p2];
    r  = ref_mem[b] - ref_mem[a];
    ref_mem[b] = r;
    npc = ($signed(r) <= 0) ? c : p0 + W'(3);
    ref_pc = npc;
  endtask

  // ------------------------------------------------------------ utilities
  logic [W-1:0] trace_addr [$];
  logic         trace_we   [$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock; samples outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    trace_addr.push_back(addr);
    trace_we.push_back(we);
    if (trace_addr.size() > 16) begin
      void'(trace_addr.pop_front());
      void'(trace_we.pop_front());
    end
    if (!we) check("data_out_when_idle", data_out, '0);
  endtask

  task automatic load_word(input logic [W-1:0] a, input logic [W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  // Puts the DUT in reset and clears both memories; areset stays high.
  task automatic prepare();
    areset    = 1'b1;
    run       = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    ref_pc = '0;
  endtask

  task automatic start_run();
    tick();
    areset = 1'b0;
    run    = 1'b1;
  endtask

  // Waits for the write of one step and checks its address/strobe sequence,
  // write data, the pc it produces and the step_done pulse.
  task automatic exec_step(input string tag, input logic [W-1:0] p0,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_data,
                           input logic [W-1:0] exp_pc);
    int           n;
    int           sz;
    int           bad;
    logic [W-1:0] seq [7];
    n = 1;
    tick();
    while (!we && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!we) begin
      errors++;
      $display("FAIL %s_write_seen actual we=0 required we=1 within 40 cycles", tag);
    end
    seq[0] = p0;
    seq[1] = p0 + W'(1);
    seq[2] = p0 + W'(2);
    seq[3] = a;
    seq[4] = b;
    seq[5] = b;
    seq[6] = b;
    sz  = trace_addr.size();
    bad = -1;
    for (int i = 0; i < 7; i++) begin
      if (bad < 0 && (trace_addr[sz-7+i] !== seq[i] ||
                      trace_we[sz-7+i] !== (i == 6))) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_addr_seq cycle %0d actual addr=%h we=%b required addr=%h we=%b",
               tag, bad, trace_addr[sz-7+bad], trace_we[sz-7+bad], seq[bad], bad == 6);
    end
    check({tag, "_data_out"}, data_out, exp_data);
    tick();
    check({tag, "_step_done_high"}, W'(step_done), W'(1));
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_halted"}, W'(halted), W'(exp_pc == '1));
    tick();
    check({tag, "_step_done_low"}, W'(step_done), W'(0));
  endtask

  task automatic wait_addr(input logic [W-1:0] target);
    int n;
    n = 0;
    tick();
    while (addr !== target && n < 20) begin
      tick();
      n++;
    end
    check("wait_addr_reached", addr, target);
  endtask

  // ------------------------------------------------------------- vectors
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] c;
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_pc;
  } vec_t;

  vec_t vecs [6];

  // --------------------------------------------------------- main sequence
  initial begin
    logic [W-1:0] p0, a, b, r, npc;
    logic         ok;
    int           diffs;

    checks    = 0;
    errors    = 0;
    areset    = 1'b1;
    run       = 1'b1;
    load_en   = 1'b0;
    clear_req = 1'b0;
    load_addr = '0;
    load_data = '0;

    // Program {10, 11, C}; mem[10]=va, mem[11]=vb; result written to mem[11].
    vecs[0] = '{16'd3,     16'd8,     16'd20, 16'd5,     16'd3};   // positive
    vecs[1] = '{16'd8,     16'd8,     16'd20, 16'd0,     16'd20};  // zero
    vecs[2] = '{16'd8,     16'd3,     16'd20, 16'hFFFB,  16'd20};  // negative
    vecs[3] = '{16'd1,     16'h8000,  16'd20, 16'h7FFF,  16'd3};   // wraps positive
    vecs[4] = '{16'h7FFF,  16'd0,     16'd40, 16'h8001,  16'd40};  // most-negative side
    vecs[5] = '{16'd0,     16'd1,     16'd50, 16'd1,     16'd3};   // smallest positive

    // Reset with run held high.
    tick();
    tick();
    check("reset_pc", pc, '0);
    check("reset_addr", addr, '0);
    check("reset_we", W'(we), '0);
    check("reset_data_out", data_out, '0);
    check("reset_step_done", W'(step_done), '0);
    check("reset_halted", W'(halted), '0);

    // Table-driven single steps.
    for (int v = 0; v < 6; v++) begin
      prepare();
      load_word(16'd0, 16'd10);
      load_word(16'd1, 16'd11);
      load_word(16'd2, vecs[v].c);
      load_word(16'd10, vecs[v].va);
      load_word(16'd11, vecs[v].vb);
      start_run();
      exec_step($sformatf("vec%0d", v), 16'd0, 16'd10, 16'd11,
                vecs[v].exp_data, vecs[v].exp_pc);
      check($sformatf("vec%0d_mem_b", v), mem[11], vecs[v].exp_data);
    end

    // Wrap: branch to 0xFFFE, then fetch 0xFFFE, 0xFFFF, 0x0000.
    prepare();
    load_word(16'd0, 16'd10);
    load_word(16'd1, 16'd11);
    load_word(16'd2, 16'hFFFE);
    load_word(16'd10, 16'd8);
    load_word(16'd11, 16'd8);
    load_word(16'hFFFE, 16'd12);
    load_word(16'hFFFF, 16'd13);
    load_word(16'd12, 16'd1);
    load_word(16'd13, 16'd5);
    start_run();
    exec_step("wrap_first", 16'd0, 16'd10, 16'd11, 16'd0, 16'hFFFE);
    exec_step("wrap_second", 16'hFFFE, 16'd12, 16'd13, 16'd4, 16'd1);

    // Halt: branch target 0xFFFF, then nothing moves for 20 cycles.
    prepare();
    load_word(16'd0, 16'd10);
    load_word(16'd1, 16'd11);
    load_word(16'd2, 16'hFFFF);
    load_word(16'd10, 16'd8);
    load_word(16'd11, 16'd8);
    start_run();
    exec_step("halt", 16'd0, 16'd10, 16'd11, 16'd0, 16'hFFFF);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      tick();
      if (we !== 1'b0 || pc !== 16'hFFFF || halted !== 1'b1 || addr !== 16'hFFFF)
        ok = 1'b0;
    end
    check("halt_hold", W'(ok), W'(1));

    // Run dropped during READ_A: the step still completes, then IDLE.
    prepare();
    load_word(16'd0, 16'd10);
    load_word(16'd1, 16'd11);
    load_word(16'd2, 16'd20);
    load_word(16'd10, 16'd3);
    load_word(16'd11, 16'd8);
    start_run();
    wait_addr(16'd10);
    run = 1'b0;
    exec_step("run_drop", 16'd0, 16'd10, 16'd11, 16'd5, 16'd3);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (addr !== 16'd3 || we !== 1'b0 || step_done !== 1'b0) ok = 1'b0;
    end
    check("run_drop_idle", W'(ok), W'(1));

    // Reset during LOAD_B: the pending write is abandoned.
    prepare();
    load_word(16'd0, 16'd10);
    load_word(16'd1, 16'd11);
    load_word(16'd2, 16'd20);
    load_word(16'd10, 16'd3);
    load_word(16'd11, 16'd8);
    start_run();
    wait_addr(16'd10);
    tick();
    tick();
    check("load_b_addr", addr, 16'd11);
    areset = 1'b1;
    tick();
    check("mid_reset_we", W'(we), '0);
    check("mid_reset_pc", pc, '0);
    check("mid_reset_addr", addr, '0);
    areset = 1'b0;
    run    = 1'b0;
    tick();
    tick();
    check("mid_reset_mem_b", mem[11], 16'd8);
    check("mid_reset_idle_pc", pc, '0);

    // Random programs against the interpreter.
    for (int t = 0; t < 10; t++) begin
      prepare();
      for (int i = 0; i < 32; i++) begin
        load_word(W'(i), ($urandom_range(0, 3) == 0) ? W'($urandom)
                                                     : W'($urandom_range(0, 31)));
      end
      start_run();
      for (int s = 0; s < 25; s++) begin
        model_step(p0, a, b, r, npc);
        exec_step($sformatf("rand%0d_%0d", t, s), p0, a, b, r, npc);
        if (npc == '1) break;
        if ($urandom_range(0, 3) == 0) begin
          run = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
          run = 1'b1;
        end
      end
      diffs = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check($sformatf("rand%0d_mem_diffs", t), W'(diffs), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=expired required=finished");
    $fatal(1, "timeout");
  end

endmodule
